// File: rtl/instr_fetch_unit.sv
// Program-counter / fetch sequencer for a combinational program ROM.
// Unconditional jumps are resolved here and are never presented. All other
// instructions reach execute through a one-entry valid/ready register.
// Execute can override the PC with a redirect, which also flushes that register.
module instr_fetch_unit #(
    parameter int                ADDR_W     = 4,
    parameter int                INST_W     = 16,
    parameter logic [3:0]        JMP_OPCODE = 4'b1000,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_inst,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [INST_W-1:0] ir_data,
    output logic [ADDR_W-1:0] ir_pc,
    input  logic              redirect_en,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              fetch_busy
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_pc;
    logic [INST_W-1:0]   r_ir_data;
    logic [ADDR_W-1:0]   r_ir_pc;
    logic                r_ir_valid;
    logic                w_advance;
    logic                w_is_jmp;

    // The slot may refill when it is empty or is being drained this edge.
    // A redirect suppresses the fetch so that the new target is fetched first.
    assign w_advance = (r_state == S_RUN) && (!r_ir_valid || ir_ready) && !redirect_en;
    assign w_is_jmp  = (rom_inst[INST_W-1 -: 4] == JMP_OPCODE);

    assign rom_addr   = r_pc;
    assign ir_valid   = r_ir_valid;
    assign ir_data    = r_ir_data;
    assign ir_pc      = r_ir_pc;
    assign fetch_busy = (r_state == S_RUN);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state follows en. A redirect leaves the state untouched.
    always_comb begin
        w_state_nxt = r_state;
        if (!redirect_en) w_state_nxt = en ? S_RUN : S_IDLE;
    end

    // PC and instruction register. Priority is redirect, then fetch, then drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_ir_valid <= 1'b0;
            r_ir_data  <= '0;
            r_ir_pc    <= '0;
        end else if (redirect_en) begin
            r_pc       <= redirect_addr;
            r_ir_valid <= 1'b0;
        end else if (w_advance) begin
            if (w_is_jmp) begin
                // The jump is absorbed here. The slot was drained or empty, so it costs one bubble.
                r_pc       <= rom_inst[ADDR_W-1:0];
                r_ir_valid <= 1'b0;
            end else begin
                r_ir_data  <= rom_inst;
                r_ir_pc    <= r_pc;
                r_ir_valid <= 1'b1;
                r_pc       <= r_pc + 1'b1;
            end
        end else if (r_ir_valid && ir_ready) begin
            r_ir_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit. Directed scenarios come first.
// After them, randomized traffic is checked by a scoreboard. Its expected stream is the
// program-order walk of the ROM: jumps are skipped, the walk restarts on redirect or reset,
// and an accepted instruction must be the next entry of that walk.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [3:0]  rom_addr;
    logic [15:0] rom_inst;
    logic        ir_valid;
    logic        ir_ready;
    logic [15:0] ir_data;
    logic [3:0]  ir_pc;
    logic        redirect_en;
    logic [3:0]  redirect_addr;
    logic        fetch_busy;

    logic [15:0] rom [16];
    logic [19:0] exp_q [$];
    int total = 0;
    int bad = 0;
    int accepts = 0;
    bit sb_on = 1'b0;

    assign rom_inst = rom[rom_addr];

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rom_addr(rom_addr), .rom_inst(rom_inst),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_data(ir_data), .ir_pc(ir_pc),
        .redirect_en(redirect_en), .redirect_addr(redirect_addr), .fetch_busy(fetch_busy)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic expect_ir(input string nm, input logic [3:0] pc, input logic [15:0] d);
        chk({nm, "_valid"}, 32'(ir_valid), 32'd1);
        chk({nm, "_pc"}, 32'(ir_pc), 32'(pc));
        chk({nm, "_data"}, 32'(ir_data), 32'(d));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected accepted stream: walk from start in program order. Jumps are skipped.
    // A jump cycle produces nothing further.
    task automatic fill(input logic [3:0] start);
        logic [3:0] pc;
        int hops;
        exp_q.delete();
        pc = start;
        for (int n = 0; n < 256; n++) begin
            hops = 0;
            while (rom[pc][15:12] == 4'h8 && hops <= 16) begin
                pc = rom[pc][3:0];
                hops++;
            end
            if (hops > 16) break;
            exp_q.push_back({pc, rom[pc]});
            pc = pc + 4'd1;
        end
    endtask

    task automatic load_base_rom();
        rom[0] = 16'h1202; rom[1] = 16'h2240; rom[2] = 16'hF200; rom[3] = 16'h8000;
        for (int i = 4; i < 15; i++) rom[i] = 16'h0100 + 16'(i);
        rom[15] = 16'h0200;
    endtask

    // Scoreboard monitor: an accept happens on the coming edge unless a redirect flushes it.
    always @(negedge clk) begin
        logic [19:0] e;
        if (sb_on && rst_n && ir_valid && ir_ready && !redirect_en) begin
            total++;
            accepts++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected got pc=%0h data=%0h exp=none", ir_pc, ir_data);
            end else begin
                e = exp_q.pop_front();
                if ({ir_pc, ir_data} !== e) begin
                    bad++;
                    $display("FAIL sb_accept got pc=%0h data=%0h exp pc=%0h data=%0h",
                             ir_pc, ir_data, e[19:16], e[15:0]);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; ir_ready = 1'b0; redirect_en = 1'b0; redirect_addr = 4'd0;
        load_base_rom();
        #3;
        chk("rst_valid", 32'(ir_valid), 32'd0);
        chk("rst_addr", 32'(rom_addr), 32'd0);
        chk("rst_busy", 32'(fetch_busy), 32'd0);
        chk("rst_data", 32'(ir_data), 32'd0);
        chk("rst_irpc", 32'(ir_pc), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // T1: straight-line fetch with a jump back to 0.
        tick(); en = 1'b1; ir_ready = 1'b1;
        tick(); chk("t1_busy", 32'(fetch_busy), 32'd1); chk("t1_idle_valid", 32'(ir_valid), 32'd0);
        tick(); expect_ir("t1_0", 4'd0, 16'h1202);
        tick(); expect_ir("t1_1", 4'd1, 16'h2240);
        ir_ready = 1'b0;
        // T2: stall with pc 1 held.
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_ir("t2_hold", 4'd1, 16'h2240);
            chk("t2_addr", 32'(rom_addr), 32'd2);
        end
        ir_ready = 1'b1;
        tick(); expect_ir("t2_2", 4'd2, 16'hF200);
        tick(); chk("t1_bubble", 32'(ir_valid), 32'd0); chk("t1_jmp_addr", 32'(rom_addr), 32'd0);
        tick(); expect_ir("t1_wrapjmp", 4'd0, 16'h1202);

        // T3: redirect to 15, then the PC wraps.
        redirect_en = 1'b1; redirect_addr = 4'd15;
        tick(); chk("t3_flush", 32'(ir_valid), 32'd0); chk("t3_addr", 32'(rom_addr), 32'd15);
        redirect_en = 1'b0;
        tick(); expect_ir("t3_15", 4'd15, 16'h0200); chk("t3_wrap", 32'(rom_addr), 32'd0);
        tick(); expect_ir("t3_0", 4'd0, 16'h1202);

        // T4: a redirect flushes the held instruction even while execute is stalled.
        ir_ready = 1'b0; redirect_en = 1'b1; redirect_addr = 4'd5;
        tick(); chk("t4_flush", 32'(ir_valid), 32'd0); chk("t4_addr", 32'(rom_addr), 32'd5);
        redirect_en = 1'b0; ir_ready = 1'b1;
        tick(); expect_ir("t4_5", 4'd5, 16'h0105);

        // T5: drop en. The pending entry is held and the PC freezes.
        ir_ready = 1'b0; en = 1'b0;
        tick(); chk("t5_busy", 32'(fetch_busy), 32'd0); expect_ir("t5_hold", 4'd5, 16'h0105);
        tick(); expect_ir("t5_hold2", 4'd5, 16'h0105); chk("t5_addr", 32'(rom_addr), 32'd6);
        ir_ready = 1'b1;
        tick(); chk("t5_drain", 32'(ir_valid), 32'd0); chk("t5_frozen", 32'(rom_addr), 32'd6);
        en = 1'b1; ir_ready = 1'b0;
        tick(); tick(); expect_ir("t5_6", 4'd6, 16'h0106);
        #2 rst_n = 1'b0;
        #1 chk("t5_async_valid", 32'(ir_valid), 32'd0);
        chk("t5_async_addr", 32'(rom_addr), 32'd0);
        chk("t5_async_busy", 32'(fetch_busy), 32'd0);
        en = 1'b0;
        @(negedge clk); rst_n = 1'b1;

        // T6: a self-jump at 3 loops until a redirect.
        rom[3] = 16'h8003;
        tick(); en = 1'b1; ir_ready = 1'b1;
        tick(); tick(); expect_ir("t6_0", 4'd0, 16'h1202);
        tick(); tick(); expect_ir("t6_2", 4'd2, 16'hF200);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_loop_valid", 32'(ir_valid), 32'd0);
            chk("t6_loop_addr", 32'(rom_addr), 32'd3);
        end
        redirect_en = 1'b1; redirect_addr = 4'd0;
        tick(); chk("t6_redir", 32'(ir_valid), 32'd0);
        redirect_en = 1'b0;
        tick(); expect_ir("t6_restart", 4'd0, 16'h1202);

        // Randomized segments: each one resets with a fresh random ROM.
        for (int seg = 0; seg < 5; seg++) begin
            rst_n = 1'b0; en = 1'b0; redirect_en = 1'b0; ir_ready = 1'b0;
            for (int i = 0; i < 16; i++) begin
                logic [15:0] v;
                v = 16'($urandom);
                if ($urandom_range(3) == 0) v[15:12] = 4'h8;
                else if (v[15:12] == 4'h8) v[15:12] = 4'h9;
                rom[i] = v;
            end
            fill(4'd0);
            sb_on = 1'b1;
            tick();
            rst_n = 1'b1;
            for (int c = 0; c < 200; c++) begin
                en = ($urandom_range(9) != 0);
                ir_ready = 1'($urandom_range(1));
                if ($urandom_range(15) == 0) begin
                    redirect_en = 1'b1;
                    redirect_addr = 4'($urandom_range(15));
                    fill(redirect_addr);
                end else begin
                    redirect_en = 1'b0;
                end
                tick();
            end
        end
        redirect_en = 1'b0;
        sb_on = 1'b0;
        chk("sb_activity", 32'(accepts > 100), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
